manchester_word_encoder: RTL and testbench

//  Parametrised successor to the single-bit NRZ-to-Manchester encoder.
//  - Accepts DATA_W-bit parallel words over a valid/ready handshake.
//  - Serialises each word and Manchester-encodes it on one output line.
//  - Sits between a framing/packet source and the line driver.
//  - Selectable polarity convention and bit order; back-to-back words with no idle gap.

---
 rtl/manchester_word_encoder.sv | 152 +++++++++++++++
 tb/tb_manchester_word_encoder.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/manchester_word_encoder.sv
// Word-wide Manchester encoder: valid/ready word in, one half-bit per clk out.
// Ports: clk, rst (async high), in_data/in_valid/in_ready, outp, out_active, done.
// Optional build macro MANCH_PARITY_EN appends an even-parity bit per frame.
module manchester_word_encoder #(
   parameter int DATA_W    = 8,
   parameter bit IEEE_POL  = 1'b1,
   parameter bit MSB_FIRST = 1'b1,
   parameter bit IDLE_LVL  = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              outp,
   output logic              out_active,
   output logic              done
);

   localparam int CW = $clog2(DATA_W);

`ifdef MANCH_PARITY_EN
   typedef enum logic [1:0] {IDLE, SEND, PAR} state_t;
`else
   typedef enum logic [1:0] {IDLE, SEND} state_t;
`endif

   state_t            state, state_n;
   logic [DATA_W-1:0] sh, sh_n, sh_shift;
   logic [CW-1:0]     cnt, cnt_n;
   logic              phase, phase_n;
   logic              outp_n, act_n, done_n;
   logic              accept, last;
   logic              first_bit, cur_bit, nxt_bit;
`ifdef MANCH_PARITY_EN
   logic              par, par_n;
`endif

   function automatic logic enc(input logic b, input logic second);
      if (IEEE_POL) return second ? b : ~b;
      else          return second ? ~b : b;
   endfunction

   // A new word may enter when idle or while the final half-bit is out.
   assign in_ready  = (state == IDLE) | done;
   assign accept    = in_valid & in_ready;
   assign last      = (cnt == CW'(DATA_W - 1));
   assign first_bit = MSB_FIRST ? in_data[DATA_W-1] : in_data[0];
   assign cur_bit   = MSB_FIRST ? sh[DATA_W-1] : sh[0];
   assign nxt_bit   = MSB_FIRST ? sh[DATA_W-2] : sh[1];
   assign sh_shift  = MSB_FIRST ? {sh[DATA_W-2:0], 1'b0}
                                : {1'b0, sh[DATA_W-1:1]};

   always_comb begin
      state_n = state;
      sh_n    = sh;
      cnt_n   = cnt;
      phase_n = phase;
      outp_n  = outp;
      act_n   = out_active;
      done_n  = 1'b0;
`ifdef MANCH_PARITY_EN
      par_n   = par;
`endif
      if (state == IDLE || done) begin
         if (accept) begin
            state_n = SEND;
            sh_n    = in_data;
            cnt_n   = '0;
            phase_n = 1'b0;
            outp_n  = enc(first_bit, 1'b0);
            act_n   = 1'b1;
`ifdef MANCH_PARITY_EN
            par_n   = ^in_data;
`endif
         end else begin
            state_n = IDLE;
            cnt_n   = '0;
            phase_n = 1'b0;
            outp_n  = IDLE_LVL;
            act_n   = 1'b0;
         end
      end else begin
         unique case (state)
            SEND: begin
               if (!phase) begin
                  outp_n  = enc(cur_bit, 1'b1);
                  phase_n = 1'b1;
`ifndef MANCH_PARITY_EN
                  done_n  = last;
`endif
               end else if (!last) begin
                  sh_n    = sh_shift;
                  cnt_n   = cnt + 1'b1;
                  phase_n = 1'b0;
                  outp_n  = enc(nxt_bit, 1'b0);
               end else begin
`ifdef MANCH_PARITY_EN
                  state_n = PAR;
                  phase_n = 1'b0;
                  outp_n  = enc(par, 1'b0);
`else
                  // Unreachable: this half is always flagged done.
                  state_n = IDLE;
                  outp_n  = IDLE_LVL;
                  act_n   = 1'b0;
`endif
               end
            end
`ifdef MANCH_PARITY_EN
            PAR: begin
               outp_n  = enc(par, 1'b1);
               phase_n = 1'b1;
               done_n  = 1'b1;
            end
`endif
            default: begin
               state_n = IDLE;
               outp_n  = IDLE_LVL;
               act_n   = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         sh         <= '0;
         cnt        <= '0;
         phase      <= 1'b0;
         outp       <= IDLE_LVL;
         out_active <= 1'b0;
         done       <= 1'b0;
`ifdef MANCH_PARITY_EN
         par        <= 1'b0;
`endif
      end else begin
         state      <= state_n;
         sh         <= sh_n;
         cnt        <= cnt_n;
         phase      <= phase_n;
         outp       <= outp_n;
         out_active <= act_n;
         done       <= done_n;
`ifdef MANCH_PARITY_EN
         par        <= par_n;
`endif
      end
   end

endmodule

// File: tb/tb_manchester_word_encoder.sv
// Directed bench for manchester_word_encoder: three parameter sets on one clock.
// Instance 0: default, 1: G.E. Thomas polarity, 2: DATA_W=4 LSB first.
module tb_manchester_word_encoder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] d   [3];
   logic       v   [3];
   logic       rdy [3];
   logic       o   [3];
   logic       act [3];
   logic       dn  [3];

   always #5 clk = ~clk;

   manchester_word_encoder u0 (
      .clk(clk), .rst(rst), .in_data(d[0]), .in_valid(v[0]),
      .in_ready(rdy[0]), .outp(o[0]), .out_active(act[0]), .done(dn[0]));

   manchester_word_encoder #(.IEEE_POL(1'b0)) u1 (
      .clk(clk), .rst(rst), .in_data(d[1]), .in_valid(v[1]),
      .in_ready(rdy[1]), .outp(o[1]), .out_active(act[1]), .done(dn[1]));

   manchester_word_encoder #(.DATA_W(4), .MSB_FIRST(1'b0)) u2 (
      .clk(clk), .rst(rst), .in_data(d[2][3:0]), .in_valid(v[2]),
      .in_ready(rdy[2]), .outp(o[2]), .out_active(act[2]), .done(dn[2]));

   typedef struct {
      int          sel;
      logic [7:0]  word;
      logic [15:0] exp;   // data half-bits, left aligned, first at bit 15
      logic [1:0]  par;   // parity half-bits when parity is built in
      int          dw;
   } vec_t;

   vec_t tbl[5];
   int   pass_cnt = 0;
   int   total    = 0;

`ifdef MANCH_PARITY_EN
   localparam int PX = 2;
`else
   localparam int PX = 0;
`endif

   task automatic chk(input string name, input logic got, input logic want);
      total++;
      if (got === want) pass_cnt++;
      else $display("FAIL %s: got %b expected %b", name, got, want);
   endtask

   function automatic logic half_exp(input int k, input int i);
      logic [15:0] e;
      logic [1:0]  p;
      e = tbl[k].exp;
      p = tbl[k].par;
      if (i < 2 * tbl[k].dw) return e[15-i];
      return (i == 2 * tbl[k].dw) ? p[1] : p[0];
   endfunction

   task automatic run_vec(input int k);
      int s, n;
      s = tbl[k].sel;
      n = 2 * tbl[k].dw + PX;
      @(negedge clk);
      chk($sformatf("v%0d ready_before", k), rdy[s], 1'b1);
      v[s] = 1'b1;
      d[s] = tbl[k].word;
      @(negedge clk);
      v[s] = 1'b0;
      d[s] = ~tbl[k].word;
      for (int i = 0; i < n; i++) begin
         chk($sformatf("v%0d outp[%0d]", k, i), o[s], half_exp(k, i));
         chk($sformatf("v%0d active[%0d]", k, i), act[s], 1'b1);
         chk($sformatf("v%0d done[%0d]", k, i), dn[s], i == n - 1);
         chk($sformatf("v%0d ready[%0d]", k, i), rdy[s], i == n - 1);
         @(negedge clk);
      end
      chk($sformatf("v%0d idle_outp", k), o[s], 1'b0);
      chk($sformatf("v%0d idle_active", k), act[s], 1'b0);
      chk($sformatf("v%0d idle_done", k), dn[s], 1'b0);
   endtask

   // 0x00 ("10" per bit) then 0xFF ("01" per bit); parity of both is 0.
   function automatic logic b2b_exp(input int i, input int n);
      int j;
      j = i % n;
      if (j < 16) return (i < n) ? (j % 2 == 0) : (j % 2 == 1);
      return j == 16;
   endfunction

   initial begin
      int n;
      for (int s = 0; s < 3; s++) begin
         v[s] = 1'b0;
         d[s] = 8'h00;
      end
      tbl[0] = '{0, 8'hA5, 16'b0110011010011001, 2'b10, 8};
      tbl[1] = '{0, 8'h07, 16'b1010101010010101, 2'b01, 8};
      tbl[2] = '{1, 8'hA5, 16'b1001100101100110, 2'b01, 8};
      tbl[3] = '{2, 8'h01, 16'b0110101000000000, 2'b01, 4};
      tbl[4] = '{0, 8'h3C, 16'b1010010101011010, 2'b10, 8};

      #2;
      for (int s = 0; s < 3; s++) begin
         chk($sformatf("rst%0d outp", s), o[s], 1'b0);
         chk($sformatf("rst%0d ready", s), rdy[s], 1'b1);
         chk($sformatf("rst%0d active", s), act[s], 1'b0);
         chk($sformatf("rst%0d done", s), dn[s], 1'b0);
      end
      @(negedge clk);
      rst = 1'b0;

      for (int k = 0; k < 4; k++) run_vec(k);

      // Back-to-back: 0xFF held valid, taken in the done cycle of 0x00.
      n = 16 + PX;
      @(negedge clk);
      v[0] = 1'b1;
      d[0] = 8'h00;
      @(negedge clk);
      d[0] = 8'hFF;
      for (int i = 0; i < 2 * n; i++) begin
         chk($sformatf("b2b outp[%0d]", i), o[0], b2b_exp(i, n));
         chk($sformatf("b2b active[%0d]", i), act[0], 1'b1);
         chk($sformatf("b2b done[%0d]", i), dn[0],
             (i == n - 1) || (i == 2 * n - 1));
         chk($sformatf("b2b ready[%0d]", i), rdy[0],
             (i == n - 1) || (i == 2 * n - 1));
         if (i == n) v[0] = 1'b0;
         @(negedge clk);
      end
      chk("b2b idle_outp", o[0], 1'b0);
      chk("b2b idle_active", act[0], 1'b0);

      // Reset in the fifth cycle of a 0xA5 frame.
      v[0] = 1'b1;
      d[0] = 8'hA5;
      @(negedge clk);
      v[0] = 1'b0;
      repeat (4) @(negedge clk);
      chk("pre_rst active", act[0], 1'b1);
      rst = 1'b1;
      #1;
      chk("mid_rst outp", o[0], 1'b0);
      chk("mid_rst ready", rdy[0], 1'b1);
      chk("mid_rst active", act[0], 1'b0);
      chk("mid_rst done", dn[0], 1'b0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst active", act[0], 1'b0);
      chk("post_rst done", dn[0], 1'b0);
      chk("post_rst outp", o[0], 1'b0);
      run_vec(4);

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
